// File: rtl/wb_master_seq_pkg.sv
// Shared types for the Wishbone pipelined initiator: FSM states, termination
// kinds, completion status codes and the captured command record.
package wb_master_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TERM_NONE = 2'd0,
    TERM_ACK  = 2'd1,
    TERM_ERR  = 2'd2,
    TERM_RTY  = 2'd3
  } term_e;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_RTY = 2'd2;
  localparam logic [1:0] ST_TMO = 2'd3;

  // Widest address the command record can hold; narrower buses zero-extend.
  localparam int unsigned ADR_W_MAX = 64;

  typedef struct packed {
    logic                 we;
    logic [ADR_W_MAX-1:0] adr;
    logic [31:0]          dat;
    logic [3:0]           sel;
  } cmd_t;

  // Simultaneous terminations resolve ack > err > rty.
  function automatic term_e resolve_term(input logic ack, input logic err, input logic rty);
    term_e t;
    if (ack) begin
      t = TERM_ACK;
    end else if (err) begin
      t = TERM_ERR;
    end else if (rty) begin
      t = TERM_RTY;
    end else begin
      t = TERM_NONE;
    end
    return t;
  endfunction

endpackage

// File: rtl/wb_master_seq_if.sv
// Wishbone B4 pipelined bus bundle between the initiator (master) and a
// register-bank target (slave).
interface wb_master_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [3:0]            sel;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  ack;
  logic                  err;
  logic                  rty;
  logic                  stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, rty, stall
  );
endinterface

// File: rtl/wb_master_seq.sv
// Wishbone B4 pipelined initiator: one command at a time, retried on rty.
// Optional abort after TIMEOUT_CYCLES when WB_MASTER_SEQ_TIMEOUT_EN is defined.
module wb_master_seq
  import wb_master_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  busy_o,
  wb_master_seq_if.master       wb
);

  state_e      state_q;
  cmd_t        cmd_q;
  logic [3:0]  retry_cnt_q;
  logic        cmd_ready_q;
  logic        cyc_q;
  logic        stb_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;
  logic [1:0]  rsp_status_q;
  logic        busy_q;

  term_e       term_s;
  logic        tmo_hit_s;
  logic        go_resp_s;
  logic        go_gap_s;
  logic [1:0]  fin_status_s;
  logic [31:0] fin_dat_s;

  // Terminations count only once the strobe has been accepted.
  always_comb begin
    term_s = TERM_NONE;
    if ((state_q == WAIT) || ((state_q == REQ) && !wb.stall)) begin
      term_s = resolve_term(wb.ack, wb.err, wb.rty);
    end else begin
      term_s = TERM_NONE;
    end
  end

  // Decide how the current bus cycle ends and what the response will carry.
  always_comb begin
    go_resp_s    = 1'b0;
    go_gap_s     = 1'b0;
    fin_status_s = ST_OK;
    fin_dat_s    = 32'd0;
    case (term_s)
      TERM_ACK: begin
        go_resp_s    = 1'b1;
        fin_status_s = ST_OK;
        fin_dat_s    = cmd_q.we ? 32'd0 : wb.dat_r;
      end
      TERM_ERR: begin
        go_resp_s    = 1'b1;
        fin_status_s = ST_ERR;
      end
      TERM_RTY: begin
        if (retry_cnt_q < 4'(MAX_RETRY)) begin
          go_gap_s = 1'b1;
        end else begin
          go_resp_s    = 1'b1;
          fin_status_s = ST_RTY;
        end
      end
      default: begin
        if (tmo_hit_s) begin
          go_resp_s    = 1'b1;
          fin_status_s = ST_TMO;
        end else begin
          go_resp_s = 1'b0;
        end
      end
    endcase
  end

`ifdef WB_MASTER_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Cycles since the first strobe of this command; held at zero while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= '0;
    end else if ((state_q inside {REQ, WAIT, GAP}) && (tmo_cnt_q != TMO_LIMIT)) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_q <= tmo_cnt_q;
    end
  end

  assign tmo_hit_s = (tmo_cnt_q == TMO_LIMIT) && (state_q inside {REQ, WAIT, GAP});
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES == 32'd0);
  assign tmo_hit_s    = 1'b0;
`endif

  // Main sequencer: state plus every registered output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      retry_cnt_q  <= 4'd0;
      cmd_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= 32'd0;
      rsp_status_q <= ST_OK;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_q.we    <= cmd_we_i;
            cmd_q.adr   <= ADR_W_MAX'(cmd_adr_i);
            cmd_q.dat   <= cmd_dat_i;
            cmd_q.sel   <= cmd_sel_i;
            retry_cnt_q <= 4'd0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ, WAIT, GAP: begin
          if (go_resp_s) begin
            state_q      <= RESP;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_dat_q    <= fin_dat_s;
            rsp_status_q <= fin_status_s;
          end else if (go_gap_s) begin
            state_q     <= GAP;
            retry_cnt_q <= retry_cnt_q + 4'd1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
          end else if (state_q == GAP) begin
            state_q <= REQ;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
          end else if ((state_q == REQ) && !wb.stall) begin
            state_q <= WAIT;
            stb_q   <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= 32'd0;
            rsp_status_q <= ST_OK;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Bits above ADDR_WIDTH are always zero.
  logic unused_adr_s;
  assign unused_adr_s = ^cmd_q.adr;

  assign wb.cyc       = cyc_q;
  assign wb.stb       = stb_q;
  assign wb.we        = cmd_q.we;
  assign wb.adr       = cmd_q.adr[ADDR_WIDTH-1:0];
  assign wb.sel       = cmd_q.sel;
  assign wb.dat_w     = cmd_q.dat;

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq: scripted slave, response scoreboard.
// Timeout scenario only runs when WB_MASTER_SEQ_TIMEOUT_EN is defined.
module tb_wb_master_seq;
  import wb_master_seq_pkg::*;

  localparam int unsigned AW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic [3:0]  cmd_sel = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;

  logic        man_stall = 1'b0;
  logic        man_ack = 1'b0;
  logic        man_err = 1'b0;
  logic        auto_ack = 1'b0;
  logic        auto_err = 1'b0;
  logic        auto_rty = 1'b0;
  logic [31:0] rd_dat = 32'd0;

  wb_master_seq_if #(.ADDR_WIDTH(AW)) wb_if ();

  assign wb_if.stall = man_stall;
  assign wb_if.ack   = auto_ack | man_ack;
  assign wb_if.err   = auto_err | man_err;
  assign wb_if.rty   = auto_rty;
  assign wb_if.dat_r = rd_dat;

  wb_master_seq #(
    .ADDR_WIDTH(AW),
    .MAX_RETRY(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat),
    .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status),
    .busy_o(busy),
    .wb(wb_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  status;
  } exp_t;

  exp_t exp_q[$];
  int   script_q[$];

  int vectors = 0;
  int miscompares = 0;

  int cycle_cnt = 0;
  int cyc_hi_cnt = 0;
  int stb_hi_cnt = 0;
  int acc_cnt = 0;
  int gap_cnt = 0;
  int bad_rep_cnt = 0;
  logic acc_q = 1'b0;
  logic [31:0] exp_adr = 32'd0;
  logic [31:0] exp_dat = 32'd0;
  logic [3:0]  exp_sel = 4'd0;

  int hs_cycle, cyc_base, stb_base, acc_base, gap_base, lat;

  // Bus activity counters, sampled like a flop at each rising edge.
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    acc_q     <= wb_if.cyc & wb_if.stb & ~wb_if.stall;
    if (wb_if.cyc) cyc_hi_cnt <= cyc_hi_cnt + 1;
    if (wb_if.stb) stb_hi_cnt <= stb_hi_cnt + 1;
    if (wb_if.cyc && wb_if.stb && !wb_if.stall) begin
      acc_cnt <= acc_cnt + 1;
      if (wb_if.adr !== exp_adr || wb_if.dat_w !== exp_dat || wb_if.sel !== exp_sel)
        bad_rep_cnt <= bad_rep_cnt + 1;
    end
    if (busy && !wb_if.cyc && !rsp_valid) gap_cnt <= gap_cnt + 1;
  end

  // Scripted slave: answers in the cycle after each accepted strobe.
  // Codes: 0 silent, 1 ack, 2 err, 3 rty, 4 err+rty, 5 ack+err.
  always @(negedge clk) begin
    int code;
    code = 0;
    if (acc_q && script_q.size() > 0) code = script_q.pop_front();
    auto_ack <= (code == 1) || (code == 5);
    auto_err <= (code == 2) || (code == 4) || (code == 5);
    auto_rty <= (code == 3) || (code == 4);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the falling edge of the first REQ cycle.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    exp_adr = adr; exp_dat = dat; exp_sel = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    hs_cycle = cycle_cnt; cyc_base = cyc_hi_cnt; stb_base = stb_hi_cnt;
    acc_base = acc_cnt;   gap_base = gap_cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    lat = cycle_cnt - hs_cycle;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.dat = 'x;
      e.status = 'x;
    end
    check({tag, "_dat"}, rsp_dat, e.dat);
    check({tag, "_status"}, 32'(rsp_status), 32'(e.status));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_dat"}, rsp_dat, e.dat);
      check({tag, "_hold_status"}, 32'(rsp_status), 32'(e.status));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cyc", 32'(wb_if.cyc), 32'd0);
    check("rst_stb", 32'(wb_if.stb), 32'd0);
    check("rst_we", 32'(wb_if.we), 32'd0);
    check("rst_adr", wb_if.adr, 32'd0);
    check("rst_sel", 32'(wb_if.sel), 32'd0);
    check("rst_dat_w", wb_if.dat_w, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Simple read, ack one cycle after the strobe
    rd_dat = 32'hDEADBEEF;
    script_q.push_back(1);
    exp_q.push_back('{32'hDEADBEEF, ST_OK});
    send_cmd(1'b0, 32'h4, 32'h0, 4'hF);
    check("t1_req_cyc", 32'(wb_if.cyc), 32'd1);
    check("t1_req_stb", 32'(wb_if.stb), 32'd1);
    check("t1_req_adr", wb_if.adr, 32'h4);
    check("t1_req_ready", 32'(cmd_ready), 32'd0);
    check("t1_req_busy", 32'(busy), 32'd1);
    tick();
    check("t1_wait_stb", 32'(wb_if.stb), 32'd0);
    check("t1_wait_cyc", 32'(wb_if.cyc), 32'd1);
    wait_rsp("t1", 2);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_cyc_cycles", 32'(cyc_hi_cnt - cyc_base), 32'd2);

    // Write with strobe stalled for four cycles
    man_stall = 1'b1;
    rd_dat = 32'hFFFFFFFF;
    script_q.push_back(1);
    exp_q.push_back('{32'h0, ST_OK});
    send_cmd(1'b1, 32'h0, 32'h12345678, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("t2_stall_stb", 32'(wb_if.stb), 32'd1);
      check("t2_stall_dat", wb_if.dat_w, 32'h12345678);
      tick();
    end
    man_stall = 1'b0;
    check("t2_last_stb", 32'(wb_if.stb), 32'd1);
    check("t2_last_dat", wb_if.dat_w, 32'h12345678);
    tick();
    check("t2_wait_stb", 32'(wb_if.stb), 32'd0);
    check("t2_wait_we", 32'(wb_if.we), 32'd1);
    wait_rsp("t2", 1);
    check("t2_stb_cycles", 32'(stb_hi_cnt - stb_base), 32'd5);
    check("t2_accepts", 32'(acc_cnt - acc_base), 32'd1);

    // Two retries then ack
    rd_dat = 32'hCAFE0001;
    script_q = '{3, 3, 1};
    exp_q.push_back('{32'hCAFE0001, ST_OK});
    send_cmd(1'b0, 32'h100, 32'h0, 4'h5);
    wait_rsp("t3", 0);
    check("t3_strobes", 32'(acc_cnt - acc_base), 32'd3);
    check("t3_gaps", 32'(gap_cnt - gap_base), 32'd2);

    // Retry on every attempt: four strobes then give up
    script_q = '{3, 3, 3, 3};
    exp_q.push_back('{32'h0, ST_RTY});
    send_cmd(1'b1, 32'h20, 32'hA5A5A5A5, 4'h3);
    wait_rsp("t4", 0);
    check("t4_strobes", 32'(acc_cnt - acc_base), 32'd4);
    check("t4_gaps", 32'(gap_cnt - gap_base), 32'd3);
    check("rep_identical", 32'(bad_rep_cnt), 32'd0);

    // err together with rty: error wins, no retry
    rd_dat = 32'h77777777;
    script_q = '{4};
    exp_q.push_back('{32'h0, ST_ERR});
    send_cmd(1'b0, 32'h8, 32'h0, 4'hF);
    wait_rsp("t5a", 0);
    check("t5a_strobes", 32'(acc_cnt - acc_base), 32'd1);
    check("t5a_gaps", 32'(gap_cnt - gap_base), 32'd0);

    // ack together with err: ack wins
    rd_dat = 32'h01020304;
    script_q = '{5};
    exp_q.push_back('{32'h01020304, ST_OK});
    send_cmd(1'b0, 32'hC, 32'h0, 4'hF);
    wait_rsp("t5b", 0);

    // Termination while stalled is ignored
    man_stall = 1'b1;
    man_err = 1'b1;
    rd_dat = 32'h55AA00FF;
    script_q = '{1};
    exp_q.push_back('{32'h55AA00FF, ST_OK});
    send_cmd(1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    check("t6_still_req", 32'(wb_if.stb), 32'd1);
    man_err = 1'b0;
    man_stall = 1'b0;
    wait_rsp("t6", 0);
    check("t6_strobes", 32'(acc_cnt - acc_base), 32'd1);

    // Ack in the same cycle the strobe is accepted
    man_ack = 1'b1;
    rd_dat = 32'h11223344;
    script_q.delete();
    exp_q.push_back('{32'h11223344, ST_OK});
    send_cmd(1'b0, 32'h14, 32'h0, 4'hF);
    tick();
    man_ack = 1'b0;
    wait_rsp("t7", 0);
    check("t7_latency", 32'(lat), 32'd2);
    check("t7_cyc_cycles", 32'(cyc_hi_cnt - cyc_base), 32'd1);

    // Reset during WAIT drops the cycle and the pending response
    script_q = '{0};
    send_cmd(1'b0, 32'h40, 32'h0, 4'hF);
    tick();
    check("t8_in_wait", 32'(wb_if.cyc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_cyc", 32'(wb_if.cyc), 32'd0);
    check("t8_stb", 32'(wb_if.stb), 32'd0);
    check("t8_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t8_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t8_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

`ifdef WB_MASTER_SEQ_TIMEOUT_EN
    // Silent slave: abort with timeout status
    script_q = '{0};
    exp_q.push_back('{32'h0, ST_TMO});
    send_cmd(1'b0, 32'h80, 32'h0, 4'hF);
    wait_rsp("t9", 0);
    check("t9_latency", 32'(lat), 32'd10);
    check("t9_cyc_cycles", 32'(cyc_hi_cnt - cyc_base), 32'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
